// File: rtl/apb_i2c_req_arbiter_pkg.sv
// Shared types and constants for the APB-to-I2C request arbiter.
// Holds the FSM encoding, the bridge register map and the round-robin pointer helper.
package apb_i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [31:0] ADDR_TX  = 32'd0;
    localparam logic [31:0] ADDR_RX  = 32'd4;
    localparam logic [31:0] ADDR_CFG = 32'd8;
    localparam logic [31:0] ADDR_TMO = 32'd12;

    // Pointer moves to the requester just after the one that was served.
    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/apb_i2c_req_arbiter_if.sv
// Requester-side and APB-side signal bundle for the arbiter.
// master = the arbiter itself; slave = the requesters plus the bridge.
interface apb_i2c_req_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: a requester raises req_valid with req_* stable; the transfer is
    // accepted in the cycle req_ready is high for it, and req_* may change after
    // that edge. rsp_valid is a one-cycle pulse that qualifies rsp_rdata/rsp_err.
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;

    logic                   PSELx;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDR_W-1:0]      PADDR;
    logic [DATA_W-1:0]      PWDATA;
    logic                   PREADY;
    logic [DATA_W-1:0]      PRDATA;
    logic                   PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PREADY, PRDATA, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PREADY, PRDATA, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_i2c_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, with wrap.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    int j;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!any_o && valid_i[j]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/apb_i2c_req_arbiter.sv
// Shares one APB bridge slave between NREQ requesters, round-robin, one
// SETUP/ACCESS transfer at a time, with a bounded wait for PREADY.
module apb_i2c_req_arbiter
    import apb_i2c_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    apb_i2c_req_arbiter_if.master   bus,
    output state_e                  dbg_state_o
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;
    logic [NREQ-1:0]     req_ready_c;
    logic [NREQ-1:0]     rsp_valid_c;
    logic                psel_c, penable_c;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            wait_cnt_q <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            wait_cnt_q <= wait_cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        wait_cnt_d  = wait_cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_c = '0;
        rsp_valid_c = '0;
        psel_c      = 1'b0;
        penable_c   = 1'b0;

        case (state_q)
            IDLE: begin
                // No accept pulse while reset is held: the latch would be discarded.
                if (pick_any && !PRESET) begin
                    req_ready_c[pick_idx] = 1'b1;
                    gnt_d   = pick_idx;
                    wr_d    = bus.req_write[pick_idx];
                    addr_d  = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d = bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                psel_c  = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                // PREADY wins over the timeout on the last allowed cycle.
                if (bus.PREADY) begin
                    rdata_d = bus.PRDATA;
                    err_d   = bus.PSLVERR;
                    state_d = DONE;
                end else if (wait_cnt_q == WCNT_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            DONE: begin
                rsp_valid_c[gnt_q] = 1'b1;
                rr_ptr_d   = IDX_W'(rr_next(int'(gnt_q), NREQ));
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.PSELx     = psel_c;
    assign bus.PENABLE   = penable_c;
    assign bus.PWRITE    = psel_c ? wr_q    : 1'b0;
    assign bus.PADDR     = psel_c ? addr_q  : '0;
    assign bus.PWDATA    = psel_c ? wdata_q : '0;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_apb_i2c_req_arbiter.sv
// Directed bench for apb_i2c_req_arbiter with a small APB bridge model
// (register map decode, programmable wait states, error injection).
module tb_apb_i2c_req_arbiter;
    import apb_i2c_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 16;

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          wait_st;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_acc;
    } vec_t;

    logic   PCLK = 1'b0;
    logic   PRESET;
    state_e dbg_state;

    apb_i2c_req_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_i2c_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- bridge model ----------------
    logic [31:0] prdata_v = '0;
    logic        slverr_v = 1'b0;
    int          wait_st  = 0;
    int          tb_acc   = 0;

    function automatic logic addr_ok(input logic [31:0] a, input logic w);
        return (a == ADDR_TX && w) || (a == ADDR_RX && !w) || a == ADDR_CFG || a == ADDR_TMO;
    endfunction

    assign bus.PREADY  = bus.PSELx && bus.PENABLE && addr_ok(bus.PADDR, bus.PWRITE) && (tb_acc >= wait_st);
    assign bus.PRDATA  = prdata_v;
    assign bus.PSLVERR = slverr_v;

    always @(posedge PCLK) begin
        tb_acc <= (bus.PSELx && bus.PENABLE && !bus.PREADY) ? tb_acc + 1 : 0;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bus"}, 64'(|{bus.PSELx, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}), 64'd0);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int id, input logic v, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[id]           = v;
        bus.req_write[id]           = w;
        bus.req_addr[id*AW +: AW]   = a;
        bus.req_wdata[id*DW +: DW]  = d;
    endtask

    task automatic run_vec(input vec_t v);
        logic [NREQ-1:0] oh;
        int k;
        int acc;
        oh       = NREQ'(1 << v.id);
        prdata_v = v.prdata;
        slverr_v = v.slverr;
        wait_st  = v.wait_st;
        drive_req(v.id, 1'b1, v.wr, v.addr, v.wdata);
        #1;
        k = 0;
        while (!bus.req_ready[v.id] && k < 8) begin
            @(negedge PCLK); #1; k++;
        end
        check("grant", 64'(bus.req_ready), 64'(oh));
        check("grant_bus_idle", 64'(bus.PSELx), 64'd0);
        @(negedge PCLK);
        drive_req(v.id, 1'b0, v.wr, v.addr, v.wdata);
        #1;
        check("setup_ctrl", 64'({bus.PSELx, bus.PENABLE, bus.PWRITE}), 64'({1'b1, 1'b0, v.wr}));
        check("setup_addr", 64'(bus.PADDR), 64'(v.addr));
        check("setup_wdata", 64'(bus.PWDATA), 64'(v.wdata));
        @(negedge PCLK); #1;
        check("access_ctrl", 64'({bus.PSELx, bus.PENABLE}), 64'b11);
        acc = 0;
        k   = 0;
        while (bus.rsp_valid == '0 && k < 40) begin
            if (bus.PSELx && bus.PENABLE && bus.PADDR == v.addr && bus.PWDATA == v.wdata) acc++;
            @(negedge PCLK); #1; k++;
        end
        check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(v.exp_rdata));
        check("rsp_err", 64'(bus.rsp_err), 64'(v.exp_err));
        check("access_cycles", 64'(acc), 64'(v.exp_acc));
        check("done_bus_idle", 64'(|{bus.PSELx, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}), 64'd0);
        @(negedge PCLK); #1;
        check("rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);
        check("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(v.exp_rdata));
        check("back_to_idle", 64'(dbg_state), 64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[8];
    vec_t pre;

    initial begin
        //            id wr     addr      wdata          prdata         se  ws  exp_rdata     err  acc
        vecs[0] = '{0, 1'b1, ADDR_TX,  32'h0000_00A5, 32'h0,         1'b0, 0,  32'h0,        1'b0, 1};
        vecs[1] = '{1, 1'b0, ADDR_RX,  32'h0,         32'h0000_1234, 1'b0, 0,  32'h0000_1234, 1'b0, 1};
        vecs[2] = '{0, 1'b1, 32'd16,   32'h0000_0011, 32'hDEAD_BEEF, 1'b0, 0,  32'h0,        1'b1, 16};
        vecs[3] = '{0, 1'b1, ADDR_CFG, 32'h0000_003C, 32'h0,         1'b1, 0,  32'h0,        1'b1, 1};
        vecs[4] = '{1, 1'b0, ADDR_TMO, 32'h0,         32'h0000_55AA, 1'b0, 3,  32'h0000_55AA, 1'b0, 4};
        vecs[5] = '{1, 1'b0, ADDR_TX,  32'h0,         32'h0000_0099, 1'b0, 0,  32'h0,        1'b1, 16};
        vecs[6] = '{0, 1'b0, ADDR_CFG, 32'h0,         32'h0000_0077, 1'b0, 15, 32'h0000_0077, 1'b0, 16};
        vecs[7] = '{1, 1'b1, ADDR_TMO, 32'h0000_F0F0, 32'h0,         1'b0, 1,  32'h0,        1'b0, 2};

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        PRESET        = 1'b1;

        repeat (3) @(negedge PCLK);
        #1;
        check_outputs_zero("in_reset");
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check_outputs_zero("after_reset");

        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            run_vec(vecs[i]);
        end

        // Reset during ACCESS of a req1 read; leave rsp_rdata non-zero first.
        @(negedge PCLK);
        pre = '{0, 1'b0, ADDR_RX, 32'h0, 32'h0000_CAFE, 1'b0, 0, 32'h0000_CAFE, 1'b0, 1};
        run_vec(pre);
        @(negedge PCLK);
        prdata_v = '0;
        wait_st  = 0;
        drive_req(1, 1'b1, 1'b0, 32'd16, 32'h0);
        #1;
        check("rst_seq_grant", 64'(bus.req_ready), 64'b10);
        @(negedge PCLK);
        drive_req(1, 1'b0, 1'b0, 32'd16, 32'h0);
        repeat (4) @(negedge PCLK);
        #1;
        check("rst_seq_in_access", 64'({bus.PSELx, bus.PENABLE}), 64'b11);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        #1;
        check_outputs_zero("mid_reset");

        // Release reset with both requesters held: grants must start at req0
        // and alternate, one transfer every 4 cycles.
        @(negedge PCLK);
        PRESET   = 1'b0;
        prdata_v = 32'h0000_4444;
        drive_req(0, 1'b1, 1'b1, ADDR_TX, 32'h0000_00C3);
        drive_req(1, 1'b1, 1'b0, ADDR_RX, 32'h0);
        #1;
        for (int c = 0; c < 16; c++) begin
            logic [NREQ-1:0] who;
            who = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr_ready_c%0d", c), 64'(bus.req_ready), (c % 4 == 0) ? 64'(who) : 64'd0);
            check($sformatf("rr_rsp_c%0d", c), 64'(bus.rsp_valid), (c % 4 == 3) ? 64'(who) : 64'd0);
            @(negedge PCLK); #1;
        end
        drive_req(0, 1'b0, 1'b1, ADDR_TX, 32'h0000_00C3);
        drive_req(1, 1'b0, 1'b0, ADDR_RX, 32'h0);
        #1;
        check("rr_end_idle", 64'(dbg_state), 64'(IDLE));
        check("rr_end_no_ready", 64'(bus.req_ready), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
